// File: rtl/max_pool_stream_if.sv
// Valid/ready stream bundle for max_pool_stream: activation input, window clear
// and registered window-maximum output.
interface max_pool_stream_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  DATA_IN_VALID;
    logic                  DATA_IN_READY;
    logic                  WINDOW_CLEAR;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_OUT_VALID;
    logic                  DATA_OUT_READY;

    // Pooling unit side.
    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        output DATA_IN_READY,
        input  WINDOW_CLEAR,
        output DATA_OUT,
        output DATA_OUT_VALID,
        input  DATA_OUT_READY
    );

    // Producer/consumer side.
    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        input  DATA_IN_READY,
        output WINDOW_CLEAR,
        input  DATA_OUT,
        input  DATA_OUT_VALID,
        output DATA_OUT_READY
    );
endinterface

// File: rtl/max_pool_stream.sv
// Streaming max-pool: emits the maximum of every POOL_SIZE accepted elements
// through a single registered output slot with valid/ready backpressure.
module max_pool_stream #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned POOL_SIZE   = 4,
    parameter bit          SIGNED_MODE = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    max_pool_stream_if.slave       stream
);
    localparam int unsigned CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POOL_SIZE - 1);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;

    logic                  in_ready;
    logic                  accept;
    logic                  consume;
    logic                  close;
    logic [DATA_WIDTH-1:0] acc_max;

    function automatic logic [DATA_WIDTH-1:0] max_of(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic a_gt_b;
        if (SIGNED_MODE)
            a_gt_b = $signed(a) > $signed(b);
        else
            a_gt_b = a > b;
        return a_gt_b ? a : b;
    endfunction

    // The slot frees up in the same cycle it is consumed, so a full pipe streams.
    assign in_ready = !dvalid_q || stream.DATA_OUT_READY;
    assign accept   = stream.DATA_IN_VALID && in_ready && !stream.WINDOW_CLEAR;
    assign consume  = dvalid_q && stream.DATA_OUT_READY;
    assign close    = accept && (cnt_q == CNT_LAST);
    assign acc_max  = max_of(acc_q, stream.DATA_IN);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;

        if (consume)
            dvalid_d = 1'b0;

        if (stream.WINDOW_CLEAR) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (close) begin
            // Window of one has no accumulated operand to compare against.
            dout_d   = (cnt_q == '0) ? stream.DATA_IN : acc_max;
            dvalid_d = 1'b1;
            cnt_d    = '0;
        end else if (accept) begin
            if (cnt_q == '0)
                acc_d = stream.DATA_IN;
            else
                acc_d = acc_max;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign stream.DATA_IN_READY  = in_ready;
    assign stream.DATA_OUT       = dout_q;
    assign stream.DATA_OUT_VALID = dvalid_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream: signed/4 instance driven from a vector
// table, plus unsigned/4 and signed/1 instances for targeted sequences.
module tb_max_pool_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        vin;
    logic        clr;
    logic        ordy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    max_pool_stream_if #(.DATA_WIDTH(16)) if_s4 ();
    max_pool_stream_if #(.DATA_WIDTH(16)) if_u4 ();
    max_pool_stream_if #(.DATA_WIDTH(16)) if_p1 ();

    assign if_s4.DATA_IN = din;  assign if_s4.DATA_IN_VALID = vin;
    assign if_s4.WINDOW_CLEAR = clr;  assign if_s4.DATA_OUT_READY = ordy;
    assign if_u4.DATA_IN = din;  assign if_u4.DATA_IN_VALID = vin;
    assign if_u4.WINDOW_CLEAR = clr;  assign if_u4.DATA_OUT_READY = ordy;
    assign if_p1.DATA_IN = din;  assign if_p1.DATA_IN_VALID = vin;
    assign if_p1.WINDOW_CLEAR = clr;  assign if_p1.DATA_OUT_READY = ordy;

    max_pool_stream #(.DATA_WIDTH(16), .POOL_SIZE(4), .SIGNED_MODE(1'b1)) u_s4 (
        .CLK(clk), .RESET(rst), .stream(if_s4.slave));
    max_pool_stream #(.DATA_WIDTH(16), .POOL_SIZE(4), .SIGNED_MODE(1'b0)) u_u4 (
        .CLK(clk), .RESET(rst), .stream(if_u4.slave));
    max_pool_stream #(.DATA_WIDTH(16), .POOL_SIZE(1), .SIGNED_MODE(1'b1)) u_p1 (
        .CLK(clk), .RESET(rst), .stream(if_p1.slave));

    typedef struct {
        logic [15:0] din;
        logic        vin;
        logic        clr;
        logic        ordy;
        logic        rst;
        logic        chk;
        logic        ev;
        logic [15:0] ed;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    // Inputs applied this cycle; expected outputs are those seen before the edge.
    function automatic void add(input logic [15:0] d, input logic v, input logic c,
                                input logic o, input logic r, input logic k,
                                input logic ev, input logic [15:0] ed, input logic er);
        vec_t t;
        t.din = d; t.vin = v; t.clr = c; t.ordy = o; t.rst = r; t.chk = k;
        t.ev = ev; t.ed = ed; t.er = er;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [15:0] d, input logic v, input logic c,
                         input logic o, input logic r);
        @(negedge clk);
        din = d; vin = v; clr = c; ordy = o; rst = r;
        #1;
    endtask

    initial begin
        din = '0; vin = 1'b0; clr = 1'b0; ordy = 1'b1; rst = 1'b1;

        // reset
        add(16'h0000, 0, 0, 1, 1, 0, 0, 16'h0000, 1);
        add(16'h0000, 0, 0, 1, 1, 1, 0, 16'h0000, 1);
        // basic signed window 3,-7,12,5 -> 12, valid for one cycle
        add(16'd3,    1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'hFFF9, 1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'd12,   1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'd5,    1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'd12,   1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'd12,   1);
        // signed compare of extremes -> 0x7FFF
        add(16'h8000, 1, 0, 1, 0, 1, 0, 16'd12,   1);
        add(16'h0001, 1, 0, 1, 0, 1, 0, 16'd12,   1);
        add(16'h7FFF, 1, 0, 1, 0, 1, 0, 16'd12,   1);
        add(16'hFFFF, 1, 0, 1, 0, 1, 0, 16'd12,   1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'h7FFF, 1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'h7FFF, 1);
        // backpressure: window 9,1,2,3 -> 9 held while ready low
        add(16'd9,    1, 0, 1, 0, 1, 0, 16'h7FFF, 1);
        add(16'd1,    1, 0, 1, 0, 1, 0, 16'h7FFF, 1);
        add(16'd2,    1, 0, 1, 0, 1, 0, 16'h7FFF, 1);
        add(16'd3,    1, 0, 1, 0, 1, 0, 16'h7FFF, 1);
        for (int i = 0; i < 5; i++)
            add(16'd1, 1, 0, 0, 0, 1, 1, 16'd9, 0);
        add(16'd1,    1, 0, 1, 0, 1, 1, 16'd9,    1);
        add(16'd2,    1, 0, 1, 0, 1, 0, 16'd9,    1);
        add(16'd3,    1, 0, 1, 0, 1, 0, 16'd9,    1);
        add(16'd4,    1, 0, 1, 0, 1, 0, 16'd9,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'd4,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'd4,    1);
        // back-to-back windows -> 4, 8, -1, 2
        add(16'd1,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd2,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd3,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd4,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd8,    1, 0, 1, 0, 1, 1, 16'd4,    1);
        add(16'd7,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd6,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd5,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'hFFFF, 1, 0, 1, 0, 1, 1, 16'd8,    1);
        add(16'hFFFF, 1, 0, 1, 0, 1, 0, 16'd8,    1);
        add(16'hFFFF, 1, 0, 1, 0, 1, 0, 16'd8,    1);
        add(16'hFFFF, 1, 0, 1, 0, 1, 0, 16'd8,    1);
        add(16'd0,    1, 0, 1, 0, 1, 1, 16'hFFFF, 1);
        add(16'hFFFB, 1, 0, 1, 0, 1, 0, 16'hFFFF, 1);
        add(16'd0,    1, 0, 1, 0, 1, 0, 16'hFFFF, 1);
        add(16'd2,    1, 0, 1, 0, 1, 0, 16'hFFFF, 1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'd2,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'd2,    1);
        // clear mid-window: 100,50, clear, 1..4 -> 4
        add(16'd100,  1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'd50,   1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'h0000, 0, 1, 1, 0, 1, 0, 16'd2,    1);
        add(16'd1,    1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'd2,    1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'd3,    1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'd4,    1, 0, 1, 0, 1, 0, 16'd2,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'd4,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'd4,    1);
        // element presented with clear is dropped: 7, clear+99, 10..13 -> 13
        add(16'd7,    1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd99,   1, 1, 1, 0, 1, 0, 16'd4,    1);
        add(16'd10,   1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd11,   1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd12,   1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'd13,   1, 0, 1, 0, 1, 0, 16'd4,    1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'd13,   1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'd13,   1);
        // reset mid-window, then -2,-9,-4,-3 -> -2
        add(16'd50,   1, 0, 1, 0, 1, 0, 16'd13,   1);
        add(16'd60,   1, 0, 1, 0, 1, 0, 16'd13,   1);
        add(16'h0000, 0, 0, 1, 1, 1, 0, 16'd13,   1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'hFFFE, 1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'hFFF7, 1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'hFFFC, 1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'hFFFD, 1, 0, 1, 0, 1, 0, 16'h0000, 1);
        add(16'h0000, 0, 0, 1, 0, 1, 1, 16'hFFFE, 1);
        add(16'h0000, 0, 0, 1, 0, 1, 0, 16'hFFFE, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].din, vecs[i].vin, vecs[i].clr, vecs[i].ordy, vecs[i].rst);
            if (vecs[i].chk) begin
                check($sformatf("v%0d valid", i), 16'(if_s4.DATA_OUT_VALID), 16'(vecs[i].ev));
                check($sformatf("v%0d dout", i),  if_s4.DATA_OUT, vecs[i].ed);
                check($sformatf("v%0d ready", i), 16'(if_s4.DATA_IN_READY), 16'(vecs[i].er));
            end
        end

        // unsigned vs signed on the same window
        apply(16'h0000, 0, 0, 1, 1);
        apply(16'h8000, 1, 0, 1, 0);
        check("u4 reset valid", 16'(if_u4.DATA_OUT_VALID), 16'h0000);
        check("u4 reset dout", if_u4.DATA_OUT, 16'h0000);
        apply(16'h0001, 1, 0, 1, 0);
        apply(16'h7FFF, 1, 0, 1, 0);
        apply(16'hFFFF, 1, 0, 1, 0);
        apply(16'h0000, 0, 0, 1, 0);
        check("s4 sign dout", if_s4.DATA_OUT, 16'h7FFF);
        check("u4 sign valid", 16'(if_u4.DATA_OUT_VALID), 16'h0001);
        check("u4 sign dout", if_u4.DATA_OUT, 16'hFFFF);
        apply(16'h0000, 0, 0, 1, 0);
        check("u4 sign consumed", 16'(if_u4.DATA_OUT_VALID), 16'h0000);

        // window of one: each element emitted the next cycle, consume+close overlap
        apply(16'h0000, 0, 0, 1, 1);
        apply(16'd5,    1, 0, 1, 0);
        check("p1 idle valid", 16'(if_p1.DATA_OUT_VALID), 16'h0000);
        apply(16'hFFFD, 1, 0, 1, 0);
        check("p1 out0 valid", 16'(if_p1.DATA_OUT_VALID), 16'h0001);
        check("p1 out0 dout", if_p1.DATA_OUT, 16'd5);
        apply(16'd7,    1, 0, 1, 0);
        check("p1 out1 valid", 16'(if_p1.DATA_OUT_VALID), 16'h0001);
        check("p1 out1 dout", if_p1.DATA_OUT, 16'hFFFD);
        apply(16'h0000, 0, 0, 1, 0);
        check("p1 out2 valid", 16'(if_p1.DATA_OUT_VALID), 16'h0001);
        check("p1 out2 dout", if_p1.DATA_OUT, 16'd7);
        apply(16'h0000, 0, 0, 1, 0);
        check("p1 drained", 16'(if_p1.DATA_OUT_VALID), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming max-reduction unit for the pooling stage of the DNN datapath.
- Consumes a valid/ready stream of fixed-point activations and emits one maximum per window of POOL_SIZE consecutive accepted elements.
- Functional counterpart of the registered minimum comparator primitive: it selects the larger operand and adds window sequencing and output buffering.
- Sits between the PE array output and the write-back buffer.

Parameters:
- DATA_WIDTH, 16, width of each data element.
- POOL_SIZE, 4, elements per window; legal values are 1..256.
- SIGNED_MODE, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  DATA_WIDTH  input element.
- DATA_IN_VALID  input  1  DATA_IN is valid this cycle.
- DATA_IN_READY  output  1  block can accept DATA_IN this cycle.
- WINDOW_CLEAR  input  1  discards the partial window in progress.
- DATA_OUT  output  DATA_WIDTH  registered window maximum.
- DATA_OUT_VALID  output  1  DATA_OUT holds an unconsumed result.
- DATA_OUT_READY  input  1  downstream consumes DATA_OUT.

Behaviour:
- Clock/reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values: on RESET=1 at a clock edge, DATA_OUT=0, DATA_OUT_VALID=0, accumulator ACC=0, element counter CNT=0. RESET overrides every other input, including a window in progress; no partial result is emitted afterwards.
- Transfer rules: input accept = DATA_IN_VALID & DATA_IN_READY. Output consume = DATA_OUT_VALID & DATA_OUT_READY.
- DATA_IN_READY = !DATA_OUT_VALID | DATA_OUT_READY (combinational). It is 1 immediately after reset.
- Compare: max(a,b) = (a > b) ? a : b. Signedness follows SIGNED_MODE. Ties return either operand; values are identical. No width growth: the result is DATA_WIDTH bits.
- Accept with CNT==0 and CNT != POOL_SIZE-1: ACC <= DATA_IN, CNT <= 1.
- Accept with 0 < CNT < POOL_SIZE-1: ACC <= max(ACC, DATA_IN), CNT <= CNT+1.
- Accept with CNT == POOL_SIZE-1 (window close):
  - DATA_OUT <= max(ACC, DATA_IN), or DATA_IN when CNT==0 (POOL_SIZE=1).
  - DATA_OUT_VALID <= 1, CNT <= 0.
- Latency: result is visible the cycle after the last element of the window is accepted. Sustained throughput is one element per cycle when DATA_OUT_READY stays high.
- Output hold: while DATA_OUT_VALID=1 and DATA_OUT_READY=0, DATA_OUT is stable and no input is accepted.
- Consume without window close: DATA_OUT_VALID <= 0.
- Consume and window close in the same cycle: DATA_OUT_VALID stays 1 and DATA_OUT takes the new result. No bubble, no loss.
- WINDOW_CLEAR=1:
  - CNT <= 0 and ACC <= 0. Any element accepted in the same cycle is dropped.
  - A pending DATA_OUT/DATA_OUT_VALID is not affected, and consume still operates.
  - Clearing at CNT==0 has no effect.
- DATA_IN_VALID=0: no state change except output consume.
- The counter never exceeds POOL_SIZE-1. It wraps to 0 only at window close, clear or reset.
- States (implicit in CNT/DATA_OUT_VALID):
  - IDLE: CNT=0, !VALID.
  - FILL: CNT>0.
  - HOLD: VALID & !READY, input stalled.
  - Transitions as above.

Test Plan:
- Basic max, signed: SIGNED_MODE=1, POOL_SIZE=4, DATA_OUT_READY=1, inputs 3, -7, 12, 5 on consecutive cycles -> DATA_OUT=12 with DATA_OUT_VALID=1 for exactly one cycle, one cycle after the 5 is accepted.
- Signedness: inputs 0x8000, 0x0001, 0x7FFF, 0xFFFF. SIGNED_MODE=1 -> 0x7FFF. SIGNED_MODE=0 -> 0xFFFF.
- Backpressure: DATA_OUT_READY=0 after the first window (result 9) -> DATA_IN_READY=0, DATA_OUT stays 9 for 5 cycles. Raise DATA_OUT_READY with second window 1, 2, 3, 4 streaming -> results 9 then 4, no duplicate, no drop.
- Back-to-back: 16 elements at one per cycle with READY=1 and windows {1,2,3,4}, {8,7,6,5}, {-1,-1,-1,-1}, {0,-5,0,2} -> outputs 4, 8, -1, 2 in consecutive windows. DATA_IN_READY is never deasserted.
- Clear and reset mid-window:
  - Accept 100, 50, then WINDOW_CLEAR, then 1, 2, 3, 4 -> output 4 (not 100).
  - Separately, assert RESET after 2 elements -> all outputs 0, next window of 4 elements produces the correct max.
- POOL_SIZE=1: inputs 5, -3, 7 -> outputs 5, -3, 7, each one cycle after acceptance.
